// File: rtl/scumvcontroller_asc_scan_driver.sv
// Collects a scan packet from the ASC byte stream, shifts it onto the SCuM-V
// analog scan chain MSB-first starting at byte 0, pulses scan_update, then
// returns a one-byte status on the ASC response stream.
module scumvcontroller_asc_scan_driver #(
    parameter int unsigned PACKET_BYTES = 22,
    parameter int unsigned CLK_DIV      = 50,
    parameter logic [7:0]  ACK_OK       = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       asc_data_valid,
    output logic       asc_data_ready,
    input  logic [7:0] asc_data_in,
    output logic       asc_response_valid,
    input  logic       asc_response_ready,
    output logic [7:0] asc_response_data,
    output logic       scan_clk,
    output logic       scan_in,
    output logic       scan_update,
    output logic       busy,
    output logic [2:0] debug_state
);

    localparam int unsigned SCAN_BITS = PACKET_BYTES * 8;
    localparam int unsigned BYTE_W    = $clog2(PACKET_BYTES);
    localparam int unsigned BIT_W     = $clog2(SCAN_BITS);
    localparam int unsigned DIV_W     = $clog2(2 * CLK_DIV + 1);

    typedef enum logic [2:0] {
        COLLECT    = 3'd0,
        SHIFT_LOW  = 3'd1,
        SHIFT_HIGH = 3'd2,
        UPDATE     = 3'd3,
        RESPOND    = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        buffer [PACKET_BYTES];
    logic [BYTE_W-1:0] byte_cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [BIT_W-1:0]  next_idx;
    logic [DIV_W-1:0]  div_cnt;
    logic              overrun;

    // Index of the bit that will be presented on the next SHIFT_LOW entry
    assign next_idx    = bit_idx + BIT_W'(1);
    assign debug_state = state;

    // Packet FSM: collect, shift low/high halves, update pulse, status response
    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= COLLECT;
            byte_cnt           <= '0;
            bit_idx            <= '0;
            div_cnt            <= '0;
            overrun            <= 1'b0;
            asc_data_ready     <= 1'b1;
            asc_response_valid <= 1'b0;
            asc_response_data  <= 8'h00;
            scan_clk           <= 1'b0;
            scan_in            <= 1'b0;
            scan_update        <= 1'b0;
            busy               <= 1'b0;
        end else begin
            // Bytes offered while not ready are dropped but remembered
            if (asc_data_valid && !asc_data_ready) begin
                overrun <= 1'b1;
            end

            case (state)
                COLLECT: begin
                    if (asc_data_valid && asc_data_ready) begin
                        buffer[byte_cnt] <= asc_data_in;
                        if (byte_cnt == BYTE_W'(PACKET_BYTES - 1)) begin
                            byte_cnt       <= '0;
                            bit_idx        <= '0;
                            div_cnt        <= '0;
                            asc_data_ready <= 1'b0;
                            busy           <= 1'b1;
                            scan_clk       <= 1'b0;
                            scan_in        <= buffer[0][7];
                            state          <= SHIFT_LOW;
                        end else begin
                            byte_cnt <= byte_cnt + BYTE_W'(1);
                        end
                    end
                end

                SHIFT_LOW: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        scan_clk <= 1'b1;
                        state    <= SHIFT_HIGH;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                SHIFT_HIGH: begin
                    if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                        div_cnt  <= '0;
                        scan_clk <= 1'b0;
                        if (bit_idx == BIT_W'(SCAN_BITS - 1)) begin
                            scan_in     <= 1'b0;
                            scan_update <= 1'b1;
                            state       <= UPDATE;
                        end else begin
                            bit_idx <= next_idx;
                            scan_in <= buffer[next_idx[BIT_W-1:3]][~next_idx[2:0]];
                            state   <= SHIFT_LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                UPDATE: begin
                    if (div_cnt == DIV_W'(2 * CLK_DIV - 1)) begin
                        div_cnt            <= '0;
                        scan_update        <= 1'b0;
                        asc_response_valid <= 1'b1;
                        // An overrun arriving on this very cycle still counts
                        asc_response_data  <= ACK_OK | {overrun | asc_data_valid, 7'd0};
                        state              <= RESPOND;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end

                RESPOND: begin
                    if (asc_response_ready) begin
                        asc_response_valid <= 1'b0;
                        asc_response_data  <= 8'h00;
                        overrun            <= 1'b0;
                        asc_data_ready     <= 1'b1;
                        busy               <= 1'b0;
                        state              <= COLLECT;
                    end
                end

                default: begin
                    state <= COLLECT;
                end
            endcase
        end
    end

endmodule
